sum_uart_tx: RTL and testbench

Downstream stage of the dual 4-bit latch: takes the two latched nibbles, adds them, and on a send request transmits the 5-bit sum as one 8N1 UART byte. Sits between the latch outputs and the serial pin of the top-level wrapper. Provides a busy flag and the captured sum for debug or display.

---
 rtl/sum_uart_pkg.sv | 21 ++
 rtl/uart_tx_core.sv | 109 ++++++++++
 rtl/sum_uart_tx.sv | 63 ++++++
 tb/tb_sum_uart_tx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the nibble-sum UART transmitter.
// Frame layout is one start bit, DATA_BITS data bits LSB first, one stop bit.
package sum_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int SUM_W      = 5;

  // Zero-extend the sum into the transmitted byte.
  function automatic logic [DATA_BITS-1:0] sum_byte(input logic [SUM_W-1:0] s);
    return {{(DATA_BITS-SUM_W){1'b0}}, s};
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter core: baud counter, bit counter, shift register and FSM.
// tx, busy and state are all flops, so nothing combinational reaches the pin.
module uart_tx_core
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  // Handshake: start is a one-cycle strobe sampled only in IDLE; data is
  // captured on that same edge. A strobe in any other state is discarded.
  tx_state_e            state_q, state_n;
  logic [15:0]          baud_q, baud_n;
  logic [2:0]           bit_q, bit_n;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 tx_q, tx_n;
  logic                 busy_q, busy_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      baud_q  <= baud_n;
      bit_q   <= bit_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
    end
  end

  always_comb begin
    state_n = state_q;
    baud_n  = baud_q + 16'd1;
    bit_n   = bit_q;
    shift_n = shift_q;
    tx_n    = tx_q;
    busy_n  = busy_q;
    unique case (state_q)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (start) begin
          state_n = START;
          shift_n = data;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (baud_q == BAUD_MAX) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = '0;
          tx_n    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_q == BAUD_MAX) begin
          baud_n = '0;
          if (bit_q == LAST_BIT) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            // Next bit is presented on the same edge the register shifts.
            shift_n = shift_q >> 1;
            bit_n   = bit_q + 3'd1;
            tx_n    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (baud_q == BAUD_MAX) begin
          state_n = IDLE;
          baud_n  = '0;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign tx        = tx_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/sum_uart_tx.sv
// Adds the two latched nibbles and sends the sum as one UART byte on a
// falling edge of the (asynchronous) send_n pin.
module sum_uart_tx
  import sum_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  input  logic             send_n,
  output logic             tx,
  output logic             busy,
  output logic [SUM_W-1:0] sum_out
);

  // Flops reset high so releasing reset never looks like a falling edge.
  logic sync1_q, sync2_q, sync3_q;
  logic req, accept;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_q;
  logic [1:0] core_state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= send_n;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign req    = sync3_q & ~sync2_q;
  assign accept = req && (core_state == IDLE);
  assign sum    = {1'b0, a} + {1'b0, b};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum;
    end
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (accept),
    .data     (sum_byte(sum)),
    .tx       (tx),
    .busy     (busy),
    .state_dbg(core_state)
  );

  assign sum_out = sum_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Directed bench for sum_uart_tx with CLKS_PER_BIT = 4: table of operand
// vectors plus hand-written sequences for the multi-cycle corner cases.
module tb_sum_uart_tx;
  import sum_uart_pkg::*;

  localparam int CPB = 4;

  localparam int M_NORM  = 0;
  localparam int M_CHG_A = 1;
  localparam int M_PULSE = 2;
  localparam int M_HOLD  = 3;
  localparam int M_RST   = 4;
  localparam int M_B2B   = 5;
  localparam int M_LATE  = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] a, b;
  logic       send_n;
  logic       tx, busy;
  logic [4:0] sum_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .a      (a),
    .b      (b),
    .send_n (send_n),
    .tx     (tx),
    .busy   (busy),
    .sum_out(sum_out)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] exp_sum;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_check(input int n, input string name);
    repeat (n) begin
      @(posedge clk); #1;
      chk({name, " tx"}, {31'd0, tx}, 32'd1);
      chk({name, " busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  // Called #1 after an edge; the next edge is E0 (first sample of send_n low).
  task automatic start_req(input logic [3:0] va, input logic [3:0] vb);
    a = va;
    b = vb;
    send_n = 1'b0;
    @(posedge clk); #1;
    chk("E0 busy", {31'd0, busy}, 32'd0);
    chk("E0 tx", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    chk("E0+1 busy", {31'd0, busy}, 32'd0);
    chk("E0+1 tx", {31'd0, tx}, 32'd1);
  endtask

  // Checks edges E0+2 .. E0+2+10*CPB cycle by cycle.
  task automatic frame_body(input logic [4:0] exp_sum, input logic [7:0] exp_byte,
                            input int mode, input logic [3:0] na, input logic [3:0] nb);
    logic [9:0] frame;
    frame = {1'b1, exp_byte, 1'b0};
    for (int k = 0; k < FRAME_BITS * CPB; k++) begin
      @(posedge clk); #1;
      chk("frame tx", {31'd0, tx}, {31'd0, frame[k / CPB]});
      chk("frame busy", {31'd0, busy}, 32'd1);
      if (k == 0) chk("captured sum_out", {27'd0, sum_out}, {27'd0, exp_sum});
      if (k == 1 && mode != M_HOLD) send_n = 1'b1;
      if (mode == M_CHG_A && k == 12) a = 4'h0;
      if (mode == M_PULSE && k == 10) send_n = 1'b0;
      if (mode == M_PULSE && k == 14) send_n = 1'b1;
      if (mode == M_B2B && k == 38) begin
        a = na;
        b = nb;
        send_n = 1'b0;
      end
      if (mode == M_LATE && k == 37) send_n = 1'b0;
      if (mode == M_RST && k == 17) begin
        reset_n = 1'b0;
        #1;
        chk("reset mid tx", {31'd0, tx}, 32'd1);
        chk("reset mid busy", {31'd0, busy}, 32'd0);
        chk("reset mid sum_out", {27'd0, sum_out}, 32'd0);
        return;
      end
    end
    @(posedge clk); #1;
    chk("end busy", {31'd0, busy}, 32'd0);
    chk("end tx", {31'd0, tx}, 32'd1);
    chk("end sum_out", {27'd0, sum_out}, {27'd0, exp_sum});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 4'h7, b: 4'h5, exp_sum: 5'd12, exp_byte: 8'h0C};
    vecs[1] = '{a: 4'hF, b: 4'hF, exp_sum: 5'd30, exp_byte: 8'h1E};
    vecs[2] = '{a: 4'h0, b: 4'h0, exp_sum: 5'd0,  exp_byte: 8'h00};
    vecs[3] = '{a: 4'h9, b: 4'h6, exp_sum: 5'd15, exp_byte: 8'h0F};
    vecs[4] = '{a: 4'h8, b: 4'h1, exp_sum: 5'd9,  exp_byte: 8'h09};
    vecs[5] = '{a: 4'hA, b: 4'hB, exp_sum: 5'd21, exp_byte: 8'h15};

    // Clock/reset: real negedge on reset_n, checked before any clock edge.
    reset_n = 1'b1;
    send_n  = 1'b1;
    a = 4'h0;
    b = 4'h0;
    #2 reset_n = 1'b0;
    #1;
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset sum_out", {27'd0, sum_out}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    idle_check(100, "post reset idle");
    chk("post reset sum_out", {27'd0, sum_out}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      start_req(vecs[i].a, vecs[i].b);
      frame_body(vecs[i].exp_sum, vecs[i].exp_byte, M_NORM, 4'h0, 4'h0);
      idle_check(5, "between vectors");
    end

    // Operand change mid-frame must not alter the byte.
    start_req(4'hF, 4'hF);
    frame_body(5'd30, 8'h1E, M_CHG_A, 4'h0, 4'h0);
    idle_check(5, "after operand change");

    // Second press while busy is dropped.
    start_req(4'h7, 4'h5);
    frame_body(5'd12, 8'h0C, M_PULSE, 4'h0, 4'h0);
    idle_check(20, "press while busy");

    // Holding send_n low gives one frame only.
    start_req(4'h9, 4'h6);
    frame_body(5'd15, 8'h0F, M_HOLD, 4'h0, 4'h0);
    idle_check(200, "send_n held low");
    send_n = 1'b1;
    idle_check(5, "hold released");

    // Reset during data bit 3, then a clean frame.
    start_req(4'hA, 4'hB);
    frame_body(5'd21, 8'h15, M_RST, 4'h0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    idle_check(10, "after mid-frame reset");
    start_req(4'h3, 4'h4);
    frame_body(5'd7, 8'h07, M_NORM, 4'h0, 4'h0);
    idle_check(5, "recovery frame");

    // Request detected on the edge after busy falls starts at once.
    start_req(4'h1, 4'h2);
    frame_body(5'd3, 8'h03, M_B2B, 4'h8, 4'h8);
    frame_body(5'd16, 8'h10, M_NORM, 4'h0, 4'h0);
    idle_check(5, "after back-to-back");

    // Request detected on the same edge busy falls is dropped.
    start_req(4'h6, 4'h6);
    frame_body(5'd12, 8'h0C, M_LATE, 4'h0, 4'h0);
    a = 4'h1;
    b = 4'h1;
    idle_check(20, "late request dropped");
    chk("late request sum_out", {27'd0, sum_out}, 32'd12);
    send_n = 1'b1;
    idle_check(5, "final idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
